// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: encodings, control bundle layout and helpers shared by the MIPS pipeline control unit
package pipe_ctrl_pkg;
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  typedef enum logic [1:0] {NPC_PC4, NPC_BR, NPC_J, NPC_JR} npc_sel_e;
  typedef enum logic [1:0] {EXT_ZERO, EXT_SIGN, EXT_LUI} ext_e;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_OR, ALU_SLT, ALU_LUI} alu_e;
  typedef enum logic [1:0] {DS_ALU, DS_DM, DS_PC8, DS_MD} ds_e;
  typedef enum logic [2:0] {MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MFHI, MD_MFLO} md_e;

  typedef struct packed {
    npc_sel_e    npc_sel;
    logic        npc_op;
    ext_e        ext_op;
    logic        alu_src;
    alu_e        alu_op;
    logic        mem_write;
    ds_e         data_src;
    logic        reg_write;
    md_e         md_op;
    logic [4:0]  a3;
    logic [1:0]  tnew;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam int OFF_TNEW    = 0;
  localparam int OFF_A3      = 2;
  localparam int OFF_MD_OP   = 7;
  localparam int OFF_RW      = 10;
  localparam int OFF_DS      = 11;
  localparam int OFF_MW      = 13;
  localparam int OFF_ALU_OP  = 14;
  localparam int OFF_ALU_SRC = 17;
  localparam int OFF_EXT     = 18;
  localparam int OFF_NPC_OP  = 20;
  localparam int OFF_NPC_SEL = 21;

  localparam ctrl_t CTRL_NOP = '0;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_W  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_E  = 2'd3;

  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_0   = 2'd0;
  localparam logic [1:0] TNEW_ALU = 2'd1;
  localparam logic [1:0] TNEW_LW  = 2'd2;

  function automatic logic hit(ctrl_t c, logic [4:0] r);
    return c.reg_write && c.a3 == r && r != 5'd0;
  endfunction

  function automatic logic [1:0] tdec(logic [1:0] t);
    return t == 2'd0 ? 2'd0 : t - 2'd1;
  endfunction
endpackage

// File: rtl/pipe_ctrl_decode.sv
// ctrl_decode: combinational ID-stage decode of one instruction into control bundle, source regs and Tuse
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic [4:0]  src_rs,
  output logic [4:0]  src_rt,
  output logic [1:0]  tuse_rs,
  output logic [1:0]  tuse_rt,
  output logic        illegal
);
  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd;
  assign op = instr[31:26];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  assign fn = instr[5:0];
  // Unused source fields read as $0 so hazard and forward logic never match on them
  assign src_rs = tuse_rs == TUSE_NONE ? 5'd0 : rs;
  assign src_rt = tuse_rt == TUSE_NONE ? 5'd0 : rt;
  always_comb begin
    ctrl    = CTRL_NOP;
    tuse_rs = TUSE_NONE;
    tuse_rt = TUSE_NONE;
    illegal = 1'b0;
    case (op)
      OP_SPECIAL: case (fn)
        FN_ADDU, FN_SUBU, FN_SLT: begin
          ctrl.alu_op    = fn == FN_ADDU ? ALU_ADD : (fn == FN_SUBU ? ALU_SUB : ALU_SLT);
          ctrl.reg_write = 1'b1;
          ctrl.a3        = rd;
          ctrl.tnew      = TNEW_ALU;
          tuse_rs        = TUSE_1;
          tuse_rt        = TUSE_1;
        end
        FN_JR: begin
          ctrl.npc_sel = NPC_JR;
          tuse_rs      = TUSE_0;
        end
        FN_JALR: begin
          ctrl.npc_sel   = NPC_JR;
          ctrl.data_src  = DS_PC8;
          ctrl.reg_write = 1'b1;
          ctrl.a3        = rd;
          ctrl.tnew      = TNEW_0;
          tuse_rs        = TUSE_0;
        end
        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
          ctrl.md_op = md_e'({1'b0, fn[1:0]} + 3'd1);
          tuse_rs    = TUSE_1;
          tuse_rt    = TUSE_1;
        end
        FN_MFHI, FN_MFLO: begin
          ctrl.md_op     = fn == FN_MFHI ? MD_MFHI : MD_MFLO;
          ctrl.data_src  = DS_MD;
          ctrl.reg_write = 1'b1;
          ctrl.a3        = rd;
          ctrl.tnew      = TNEW_ALU;
        end
        default: illegal = instr != 32'd0;
      endcase
      OP_BEQ, OP_BNE: begin
        ctrl.npc_sel = NPC_BR;
        ctrl.npc_op  = op[0];
        ctrl.ext_op  = EXT_SIGN;
        tuse_rs      = TUSE_0;
        tuse_rt      = TUSE_0;
      end
      OP_ADDIU, OP_ORI: begin
        ctrl.ext_op    = op == OP_ADDIU ? EXT_SIGN : EXT_ZERO;
        ctrl.alu_op    = op == OP_ADDIU ? ALU_ADD : ALU_OR;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.a3        = rt;
        ctrl.tnew      = TNEW_ALU;
        tuse_rs        = TUSE_1;
      end
      OP_LUI: begin
        ctrl.ext_op    = EXT_LUI;
        ctrl.alu_op    = ALU_LUI;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.a3        = rt;
        ctrl.tnew      = TNEW_ALU;
      end
      OP_LW: begin
        ctrl.ext_op    = EXT_SIGN;
        ctrl.alu_src   = 1'b1;
        ctrl.data_src  = DS_DM;
        ctrl.reg_write = 1'b1;
        ctrl.a3        = rt;
        ctrl.tnew      = TNEW_LW;
        tuse_rs        = TUSE_1;
      end
      OP_SW: begin
        ctrl.ext_op    = EXT_SIGN;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        tuse_rs        = TUSE_1;
        tuse_rt        = TUSE_2;
      end
      OP_J: ctrl.npc_sel = NPC_J;
      OP_JAL: begin
        ctrl.npc_sel   = NPC_J;
        ctrl.data_src  = DS_PC8;
        ctrl.reg_write = 1'b1;
        ctrl.a3        = 5'd31;
        ctrl.tnew      = TNEW_0;
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: E/M/W control registers, Tuse/Tnew hazard detection, forwarding selects and mult/div busy window
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int FWD_EN   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       instr_D,
  input  logic              mem_wait,
  output logic              stall_D,
  output logic              illegal_D,
  output logic [CTRL_W-1:0] ctrl_E,
  output logic [CTRL_W-1:0] ctrl_M,
  output logic [CTRL_W-1:0] ctrl_W,
  output logic [1:0]        fwd_rs_D,
  output logic [1:0]        fwd_rt_D,
  output logic [1:0]        fwd_rs_E,
  output logic [1:0]        fwd_rt_E,
  output logic              fwd_rt_M,
  output logic              md_start,
  output logic              md_busy
);
  localparam int CW = $clog2((MULT_LAT > DIV_LAT ? MULT_LAT : DIV_LAT) + 1);

  ctrl_t          dec_c, e_q, e_d, m_q, m_d, w_q, w_d;
  logic [4:0]     src_rs, src_rt, rs_e_q, rs_e_d, rt_e_q, rt_e_d, rt_m_q, rt_m_d;
  logic [1:0]     tuse_rs, tuse_rt;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           data_hz, md_hz;

  ctrl_decode u_dec (
    .instr   (instr_D),
    .ctrl    (dec_c),
    .src_rs  (src_rs),
    .src_rt  (src_rt),
    .tuse_rs (tuse_rs),
    .tuse_rt (tuse_rt),
    .illegal (illegal_D)
  );

  // Without forwarding any in-flight writer in E or M blocks; W is covered by write-first RF
  function automatic logic hz(ctrl_t e, ctrl_t m, logic [4:0] r, logic [1:0] tuse);
    if (FWD_EN == 0) return hit(e, r) || hit(m, r);
    return hit(e, r) ? e.tnew > tuse : hit(m, r) && m.tnew > tuse;
  endfunction

  function automatic logic [1:0] fwd_d(ctrl_t e, ctrl_t m, ctrl_t w, logic [4:0] r);
    return hit(e, r) ? ((e.tnew == 2'd0 && e.data_src == DS_PC8) ? FWD_E : FWD_RF) :
           hit(m, r) ? (m.tnew == 2'd0 ? FWD_M : FWD_RF) :
           hit(w, r) ? FWD_W : FWD_RF;
  endfunction

  function automatic logic [1:0] fwd_e(ctrl_t m, ctrl_t w, logic [4:0] r);
    return hit(m, r) ? (m.tnew == 2'd0 ? FWD_M : FWD_RF) : hit(w, r) ? FWD_W : FWD_RF;
  endfunction

  always_comb begin
    data_hz  = hz(e_q, m_q, src_rs, tuse_rs) || hz(e_q, m_q, src_rt, tuse_rt);
    md_start = e_q.md_op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} && !mem_wait;
    md_busy  = md_start || cnt_q != '0;
    md_hz    = dec_c.md_op != MD_NONE && md_busy;
    stall_D  = data_hz || md_hz;
    fwd_rs_D = FWD_EN != 0 ? fwd_d(e_q, m_q, w_q, src_rs) : FWD_RF;
    fwd_rt_D = FWD_EN != 0 ? fwd_d(e_q, m_q, w_q, src_rt) : FWD_RF;
    fwd_rs_E = FWD_EN != 0 ? fwd_e(m_q, w_q, rs_e_q) : FWD_RF;
    fwd_rt_E = FWD_EN != 0 ? fwd_e(m_q, w_q, rt_e_q) : FWD_RF;
    fwd_rt_M = FWD_EN != 0 && hit(w_q, rt_m_q);
  end

  // The busy counter runs on every edge, even while mem_wait freezes the pipe
  always_comb begin
    cnt_d = md_start ? (e_q.md_op inside {MD_DIV, MD_DIVU} ? CW'(DIV_LAT) : CW'(MULT_LAT)) :
            (cnt_q != '0 ? cnt_q - CW'(1) : cnt_q);
    e_d    = mem_wait ? e_q : (stall_D ? CTRL_NOP : dec_c);
    rs_e_d = mem_wait ? rs_e_q : (stall_D ? 5'd0 : src_rs);
    rt_e_d = mem_wait ? rt_e_q : (stall_D ? 5'd0 : src_rt);
    m_d      = e_q;
    m_d.tnew = tdec(e_q.tnew);
    if (mem_wait) m_d = m_q;
    rt_m_d   = mem_wait ? rt_m_q : rt_e_q;
    w_d      = m_q;
    w_d.tnew = tdec(m_q.tnew);
    if (mem_wait) w_d = w_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_q    <= CTRL_NOP;
      m_q    <= CTRL_NOP;
      w_q    <= CTRL_NOP;
      rs_e_q <= '0;
      rt_e_q <= '0;
      rt_m_q <= '0;
      cnt_q  <= '0;
    end else begin
      e_q    <= e_d;
      m_q    <= m_d;
      w_q    <= w_d;
      rs_e_q <= rs_e_d;
      rt_e_q <= rt_e_d;
      rt_m_q <= rt_m_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ctrl_E = e_q;
  assign ctrl_M = m_q;
  assign ctrl_W = w_q;
endmodule
